// File: rtl/gate_controller.sv
// gate_controller: controls the barriers of a car park with two entry lanes
// and two exit lanes. Each lane runs its own FSM:
//   IDLE -> PEND -> ISSUE -> CHECK -> OPEN (16 cycles) or REJECT (1 cycle) -> IDLE
// Inside each direction, a round-robin arbiter lets one lane at a time send its
// event to the downstream parking counter. The barrier decision then waits for
// that counter's reject flag.
//
// Ports:
//   clk, reset             single clock; reset is synchronous and active-high
//   ent_sense/ent_uni[1:0] entry loop sensors and badge class (1 = university)
//   ext_sense/ext_uni[1:0] exit loop sensors and badge class
//   illegal_enter/exit     reject flags returned by the parking counter
//   car_entered/exited     one-cycle event pulses to the parking counter
//   is_uni_car_*           class of the event; valid only with its pulse
//   ent_open/ext_open      barrier-open level per lane
//   ent_reject/ext_reject  one-cycle refusal indication per lane
//   drop_cnt               saturating count of detections ignored on busy lanes
module gate_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ent_sense,
  input  logic [1:0] ent_uni,
  input  logic [1:0] ext_sense,
  input  logic [1:0] ext_uni,
  input  logic       illegal_enter,
  input  logic       illegal_exit,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic [1:0] ent_open,
  output logic [1:0] ext_open,
  output logic [1:0] ent_reject,
  output logic [1:0] ext_reject,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, PEND, ISSUE, CHECK, OPEN, REJECT} state_t;

  // Lanes 0/1 are entry lanes 0/1; lanes 2/3 are exit lanes 0/1.
  state_t     state_q [4];
  state_t     state_d [4];
  logic [3:0] tmr_q   [4];
  logic [3:0] tmr_d   [4];
  logic [3:0] sense_q, sense_d;
  logic [3:0] uni_q, uni_d;
  logic [1:0] ptr_q, ptr_d;      // bit 0: entry pointer, bit 1: exit pointer
  logic [7:0] drop_cnt_q, drop_cnt_d;

  logic       car_entered_q, car_entered_d;
  logic       is_uni_ent_q, is_uni_ent_d;
  logic       car_exited_q, car_exited_d;
  logic       is_uni_ext_q, is_uni_ext_d;
  logic [3:0] open_q, open_d;
  logic [3:0] reject_q, reject_d;

  logic [3:0] sense_in, uni_in, det, gnt, flag_vec;
  logic [2:0] drop_inc;
  logic [8:0] drop_sum;

  assign sense_in = {ext_sense, ent_sense};
  assign uni_in   = {ext_uni, ent_uni};
  assign det      = sense_in & ~sense_q;
  assign flag_vec = {illegal_exit, illegal_exit, illegal_enter, illegal_enter};

  // One arbiter per direction. A direction is frozen while any of its lanes
  // has an event on the wire (ISSUE) or waits for the counter's verdict (CHECK).
  for (genvar gi = 0; gi < 2; gi++) begin : g_arb
    logic busy, req_lo, req_hi, gnt_lo;
    assign busy   = (state_q[2*gi] inside {ISSUE, CHECK}) ||
                    (state_q[2*gi+1] inside {ISSUE, CHECK});
    assign req_lo = (state_q[2*gi] == PEND);
    assign req_hi = (state_q[2*gi+1] == PEND);
    assign gnt_lo = !busy && req_lo && (!req_hi || !ptr_q[gi]);
    assign gnt[2*gi]   = gnt_lo;
    assign gnt[2*gi+1] = !busy && req_hi && !gnt_lo;
  end

  always_comb begin
    sense_d  = sense_in;
    uni_d    = uni_q;
    ptr_d    = ptr_q;
    drop_inc = 3'd0;
    for (int l = 0; l < 4; l++) begin
      state_d[l] = state_q[l];
      tmr_d[l]   = tmr_q[l];
      case (state_q[l])
        IDLE: begin
          if (det[l]) begin
            state_d[l] = PEND;
            uni_d[l]   = uni_in[l];
          end
        end
        PEND:   if (gnt[l]) state_d[l] = ISSUE;
        ISSUE:  state_d[l] = CHECK;
        CHECK: begin
          if (flag_vec[l]) begin
            state_d[l] = REJECT;
          end else begin
            state_d[l] = OPEN;
            tmr_d[l]   = 4'd0;
          end
        end
        OPEN: begin
          if (tmr_q[l] == 4'd15) state_d[l] = IDLE;
          else                   tmr_d[l]   = tmr_q[l] + 4'd1;
        end
        REJECT:  state_d[l] = IDLE;
        default: state_d[l] = IDLE;
      endcase
      if (det[l] && state_q[l] != IDLE) drop_inc = drop_inc + 3'd1;
    end

    // Pointer moves to the lane that was not just served.
    for (int d = 0; d < 2; d++) begin
      if (gnt[2*d])        ptr_d[d] = 1'b1;
      else if (gnt[2*d+1]) ptr_d[d] = 1'b0;
    end

    // Up to four drops can land in one cycle; bit 8 flags overflow past 255.
    drop_sum   = {1'b0, drop_cnt_q} + {6'd0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Outputs are decoded from the next state so each registered output
    // lines up with the cycle its lane spends in the matching state.
    car_entered_d = (state_d[0] == ISSUE) || (state_d[1] == ISSUE);
    is_uni_ent_d  = ((state_d[0] == ISSUE) && uni_d[0]) ||
                    ((state_d[1] == ISSUE) && uni_d[1]);
    car_exited_d  = (state_d[2] == ISSUE) || (state_d[3] == ISSUE);
    is_uni_ext_d  = ((state_d[2] == ISSUE) && uni_d[2]) ||
                    ((state_d[3] == ISSUE) && uni_d[3]);
    for (int l = 0; l < 4; l++) begin
      open_d[l]   = (state_d[l] == OPEN);
      reject_d[l] = (state_d[l] == REJECT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < 4; l++) begin
        state_q[l] <= IDLE;
        tmr_q[l]   <= 4'd0;
      end
      sense_q       <= 4'd0;
      uni_q         <= 4'd0;
      ptr_q         <= 2'd0;
      drop_cnt_q    <= 8'd0;
      car_entered_q <= 1'b0;
      is_uni_ent_q  <= 1'b0;
      car_exited_q  <= 1'b0;
      is_uni_ext_q  <= 1'b0;
      open_q        <= 4'd0;
      reject_q      <= 4'd0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        state_q[l] <= state_d[l];
        tmr_q[l]   <= tmr_d[l];
      end
      sense_q       <= sense_d;
      uni_q         <= uni_d;
      ptr_q         <= ptr_d;
      drop_cnt_q    <= drop_cnt_d;
      car_entered_q <= car_entered_d;
      is_uni_ent_q  <= is_uni_ent_d;
      car_exited_q  <= car_exited_d;
      is_uni_ext_q  <= is_uni_ext_d;
      open_q        <= open_d;
      reject_q      <= reject_d;
    end
  end

  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = is_uni_ent_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_exited  = is_uni_ext_q;
  assign ent_open           = open_q[1:0];
  assign ext_open           = open_q[3:2];
  assign ent_reject         = reject_q[1:0];
  assign ext_reject         = reject_q[3:2];
  assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_gate_controller.sv
// Randomized bench for gate_controller. The reference model tracks each lane
// as an event timeline (pending flag, issue cycle, verdict). Expected outputs
// come from time offsets taken from the issue cycle.
module tb_gate_controller;

  logic       clk, reset;
  logic [1:0] ent_sense, ent_uni, ext_sense, ext_uni;
  logic       illegal_enter, illegal_exit;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [1:0] ent_open, ext_open, ent_reject, ext_reject;
  logic [7:0] drop_cnt;

  gate_controller dut (
    .clk(clk), .reset(reset),
    .ent_sense(ent_sense), .ent_uni(ent_uni),
    .ext_sense(ext_sense), .ext_uni(ext_uni),
    .illegal_enter(illegal_enter), .illegal_exit(illegal_exit),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .ent_open(ent_open), .ext_open(ext_open),
    .ent_reject(ent_reject), .ext_reject(ext_reject),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_act [4];   // lane holds an event (possibly finished)
  bit         m_pend[4];   // waiting for a grant
  bit         m_iss [4];   // event was granted at cycle m_t0
  bit         m_rej [4];   // counter refused the event
  bit         m_uni [4];
  int         m_t0  [4];
  bit [3:0]   m_prev;
  bit [1:0]   m_ptr;
  int         m_drop;
  int         cyc;
  bit [3:0]   e_pulse, e_open, e_rejo;
  bit         e_ceu, e_cxu;

  function automatic bit lane_idle(int l, int c);
    if (!m_act[l]) return 1'b1;
    if (!m_iss[l]) return 1'b0;
    return m_rej[l] ? (c >= m_t0[l] + 3) : (c >= m_t0[l] + 18);
  endfunction

  // Consumes the inputs of cycle 'cyc' and predicts outputs of cycle cyc+1.
  task automatic model_step(input bit rst, input bit [3:0] sense, input bit [3:0] uni,
                            input bit ie, input bit ix);
    int n;
    n = cyc + 1;
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        m_act[l] = 0; m_pend[l] = 0; m_iss[l] = 0; m_rej[l] = 0; m_uni[l] = 0; m_t0[l] = 0;
      end
      m_prev = '0; m_ptr = '0; m_drop = 0;
      e_pulse = '0; e_open = '0; e_rejo = '0; e_ceu = 0; e_cxu = 0;
      cyc = n;
      return;
    end
    // verdict arrives one cycle after the pulse
    for (int l = 0; l < 4; l++)
      if (m_act[l] && m_iss[l] && cyc == m_t0[l] + 1) m_rej[l] = (l < 2) ? ie : ix;
    // grants, based on who was pending during this cycle
    for (int d = 0; d < 2; d++) begin
      bit blocked;
      int g;
      blocked = 0;
      g = -1;
      for (int l = 2*d; l < 2*d + 2; l++)
        if (m_act[l] && m_iss[l] && (cyc == m_t0[l] || cyc == m_t0[l] + 1)) blocked = 1;
      if (!blocked) begin
        if (m_pend[2*d] && (!m_pend[2*d+1] || m_ptr[d] == 0)) g = 2*d;
        else if (m_pend[2*d+1]) g = 2*d + 1;
      end
      if (g >= 0) begin
        m_pend[g] = 0; m_iss[g] = 1; m_rej[g] = 0; m_t0[g] = n;
        m_ptr[d] = (g == 2*d);
      end
    end
    // detections
    for (int l = 0; l < 4; l++) begin
      if (sense[l] && !m_prev[l]) begin
        if (lane_idle(l, cyc)) begin
          m_act[l] = 1; m_pend[l] = 1; m_iss[l] = 0; m_rej[l] = 0; m_uni[l] = uni[l];
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    m_prev = sense;
    for (int l = 0; l < 4; l++) begin
      e_pulse[l] = m_act[l] && m_iss[l] && n == m_t0[l];
      e_open[l]  = m_act[l] && m_iss[l] && !m_rej[l] && n >= m_t0[l] + 2 && n <= m_t0[l] + 17;
      e_rejo[l]  = m_act[l] && m_iss[l] && m_rej[l] && n == m_t0[l] + 2;
    end
    e_ceu = (e_pulse[0] && m_uni[0]) || (e_pulse[1] && m_uni[1]);
    e_cxu = (e_pulse[2] && m_uni[2]) || (e_pulse[3] && m_uni[3]);
    cyc = n;
  endtask

  task automatic compare_all();
    check("car_entered", 32'(car_entered), 32'(e_pulse[0] | e_pulse[1]));
    check("is_uni_ent",  32'(is_uni_car_entered), 32'(e_ceu));
    check("car_exited",  32'(car_exited), 32'(e_pulse[2] | e_pulse[3]));
    check("is_uni_ext",  32'(is_uni_car_exited), 32'(e_cxu));
    check("ent_open",    32'(ent_open), 32'(e_open[1:0]));
    check("ext_open",    32'(ext_open), 32'(e_open[3:2]));
    check("ent_reject",  32'(ent_reject), 32'(e_rejo[1:0]));
    check("ext_reject",  32'(ext_reject), 32'(e_rejo[3:2]));
    check("drop_cnt",    32'(drop_cnt), 32'(m_drop));
    if (e_pulse[1:0] != 0)
      $display("cycle %0d: entry event lane %0d uni=%0d", cyc, e_pulse[1], e_ceu);
    if (e_pulse[3:2] != 0)
      $display("cycle %0d: exit event lane %0d uni=%0d", cyc, e_pulse[3], e_cxu);
  endtask

  // Drive one cycle of stimulus, advance the model and check after the edge.
  task automatic run_cycle(input bit rst, input bit [3:0] sense, input bit [3:0] uni,
                           input bit ie, input bit ix);
    @(negedge clk);
    reset = rst;
    ent_sense = sense[1:0]; ext_sense = sense[3:2];
    ent_uni = uni[1:0];     ext_uni = uni[3:2];
    illegal_enter = ie;     illegal_exit = ix;
    model_step(rst, sense, uni, ie, ix);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    bit [3:0] s, u;
    cyc = 0;
    reset = 1'b1;
    ent_sense = '0; ext_sense = '0; ent_uni = '0; ext_uni = '0;
    illegal_enter = 1'b0; illegal_exit = 1'b0;
    s = '0;

    // Reset with sensors high: they must be detected right after release.
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 4'hF, 4'(i), 1'b0, 1'b0);
    s = 4'hF;

    // Random traffic with periodic simultaneous rises and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      if (i % 97 == 0)      s = 4'h0;
      else if (i % 97 == 1) s = 4'hF;
      else
        for (int l = 0; l < 4; l++)
          if ($urandom_range(7) == 0) s[l] = ~s[l];
      u = 4'($urandom);
      rst = ($urandom_range(255) == 0);
      run_cycle(rst, s, u, 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
    end

    // Hammer entry lane 0 so most rises hit a busy lane.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 700; i++)
      run_cycle(1'b0, {3'b000, 1'(i % 2)}, 4'($urandom), 1'b0, 1'($urandom_range(1)));
    check("drop_saturated", 32'(drop_cnt), 32'd255);

    // Reset in flight must clear everything on the next cycle.
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    run_cycle(1'b0, 4'h3, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'h3, 4'h1, 1'b0, 1'b0);
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    check("reset_open", 32'({ent_open, ext_open, ent_reject, ext_reject}), 32'd0);
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
